// File: rtl/div_iter32.sv
// div_iter32: iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// Quotient goes to LO, remainder to HI. Each trial subtract is done by two
// chained clfa16 carry-lookahead adders in subtract mode.

// clfa16: 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
// CARRY_O[i] is the carry out of bit i, so CARRY_O[15] chains to the next slice.
module clfa16 (
   input  logic [15:0] ADDER1,
   input  logic [15:0] ADDER2,
   input  logic        CARRY_I,
   output logic [15:0] SUM,
   output logic [15:0] CARRY_O
);

   logic [15:0] g;
   logic [15:0] p;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [4:1]  cb;
   logic [15:0] c_in;

   assign g = ADDER1 & ADDER2;
   assign p = ADDER1 ^ ADDER2;

   // Group generate / propagate for each 4-bit block
   for (genvar k = 0; k < 4; k++) begin : grp
      localparam int B = 4 * k;
      assign gg[k] = g[B+3]
                   | (p[B+3] & g[B+2])
                   | (p[B+3] & p[B+2] & g[B+1])
                   | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp[k] = p[B+3] & p[B+2] & p[B+1] & p[B];
   end

   // Block carries, all expressed directly from CARRY_I (no ripple between blocks)
   assign cb[1] = gg[0] | (gp[0] & CARRY_I);
   assign cb[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & CARRY_I);
   assign cb[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & CARRY_I);
   assign cb[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & CARRY_I);

   // In-group carries from the block carry-in
   for (genvar k = 0; k < 4; k++) begin : bit_c
      localparam int B = 4 * k;
      logic cin_blk;
      if (k == 0) begin : c0
         assign cin_blk = CARRY_I;
      end else begin : cn
         assign cin_blk = cb[k];
      end
      assign c_in[B]   = cin_blk;
      assign c_in[B+1] = g[B] | (p[B] & cin_blk);
      assign c_in[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cin_blk);
      assign c_in[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                       | (p[B+2] & p[B+1] & p[B] & cin_blk);
      assign CARRY_O[B]   = c_in[B+1];
      assign CARRY_O[B+1] = c_in[B+2];
      assign CARRY_O[B+2] = c_in[B+3];
      assign CARRY_O[B+3] = cb[k+1];
   end

   assign SUM = p ^ c_in;

endmodule

// div_iter32: START/BUSY/DONE handshake, CANCEL aborts, one division in flight.
module div_iter32 #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SIGNED,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   input  logic             CANCEL,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER
);

   localparam int            CW   = $clog2(ITER);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dsr;
   logic             qneg;
   logic             rneg;
   logic             dz;

   logic [WIDTH-1:0] mag_dividend;
   logic [WIDTH-1:0] mag_divisor;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] dsr_n;
   logic [31:0]      diff;
   logic [15:0]      lo_co;
   logic [15:0]      hi_co;
   logic             ok;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             unused_co;

   // Operand magnitudes; only signed requests take absolute values
   always_comb begin
      mag_dividend = DIVIDEND;
      mag_divisor  = DIVISOR;
      if (SIGNED && DIVIDEND[WIDTH-1]) mag_dividend = -DIVIDEND;
      if (SIGNED && DIVISOR[WIDTH-1])  mag_divisor  = -DIVISOR;
   end

   // Shifted partial remainder presented to the trial subtractor
   assign rem_sh = {rem[WIDTH-1:0], dvd[WIDTH-1]};
   assign dsr_n  = ~dsr;

   clfa16 u_sub_lo (
      .ADDER1  (rem_sh[15:0]),
      .ADDER2  (dsr_n[15:0]),
      .CARRY_I (1'b1),
      .SUM     (diff[15:0]),
      .CARRY_O (lo_co)
   );

   clfa16 u_sub_hi (
      .ADDER1  (rem_sh[31:16]),
      .ADDER2  (dsr_n[31:16]),
      .CARRY_I (lo_co[15]),
      .SUM     (diff[31:16]),
      .CARRY_O (hi_co)
   );

   // Only the slice carry-outs matter; the inner bits are folded away here
   assign unused_co = ^{lo_co[14:0], hi_co[14:0]};

   // Carry out high means no borrow; a set bit 32 always fits the subtract
   assign ok = rem_sh[WIDTH] | hi_co[15];

   // Final result with sign fixup; divide-by-zero bypasses the fixup
   always_comb begin
      q_fix = qneg ? -dvd : dvd;
      r_fix = rneg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
      if (dz) begin
         q_fix = '1;
         r_fix = dvd;
      end
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         rem       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         qneg      <= 1'b0;
         rneg      <= 1'b0;
         dz        <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         QUOTIENT  <= '0;
         REMAINDER <= '0;
      end else begin
         case (state)
            IDLE: begin
               // While DONE is high BUSY is still shown, so START waits one cycle
               DONE <= 1'b0;
               BUSY <= 1'b0;
               if (!DONE && START && !CANCEL) begin
                  BUSY <= 1'b1;
                  qneg <= SIGNED & (DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1]);
                  rneg <= SIGNED & DIVIDEND[WIDTH-1];
                  rem  <= '0;
                  cnt  <= '0;
                  dsr  <= mag_divisor;
                  if (DIVISOR == '0) begin
                     dz    <= 1'b1;
                     dvd   <= DIVIDEND;
                     state <= FIX;
                  end else begin
                     dz    <= 1'b0;
                     dvd   <= mag_dividend;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (CANCEL) begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end else begin
                  rem <= ok ? {1'b0, diff} : rem_sh;
                  dvd <= {dvd[WIDTH-2:0], ok};
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) state <= FIX;
               end
            end
            FIX: begin
               if (CANCEL) begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end else begin
                  QUOTIENT  <= q_fix;
                  REMAINDER <= r_fix;
                  DONE      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               BUSY  <= 1'b0;
               DONE  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter32.sv
// tb_div_iter32: directed corner cases plus randomized divisions, all checked
// every cycle against a behavioural model built on plain 64-bit arithmetic.
module tb_div_iter32;

   logic        CLK;
   logic        RST;
   logic        START;
   logic        SIGNED;
   logic [31:0] DIVIDEND;
   logic [31:0] DIVISOR;
   logic        CANCEL;
   logic        BUSY;
   logic        DONE;
   logic [31:0] QUOTIENT;
   logic [31:0] REMAINDER;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   div_iter32 #(.WIDTH(32), .ITER(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .SIGNED    (SIGNED),
      .DIVIDEND  (DIVIDEND),
      .DIVISOR   (DIVISOR),
      .CANCEL    (CANCEL),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .QUOTIENT  (QUOTIENT),
      .REMAINDER (REMAINDER)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference division from magnitudes; divide by zero is Q=all ones, R=dividend
   task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
      longint unsigned ma, mb, mq, mr;
      dz = (b == 32'd0);
      if (dz) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         ma = (s && a[31]) ? (64'h1_0000_0000 - 64'(a)) : 64'(a);
         mb = (s && b[31]) ? (64'h1_0000_0000 - 64'(b)) : 64'(b);
         mq = ma / mb;
         mr = ma % mb;
         q  = (s && (a[31] ^ b[31])) ? 32'(64'd0 - mq) : 32'(mq);
         r  = (s && a[31]) ? 32'(64'd0 - mr) : 32'(mr);
      end
   endtask

   // Cycle-level model: edge count of the result write, busy window, held outputs
   int          cyc = 0;
   int          m_wr = 0;
   bit          m_active = 0;
   bit          m_done = 0;
   logic [31:0] m_q = '0;
   logic [31:0] m_r = '0;
   logic [31:0] p_q;
   logic [31:0] p_r;
   logic        p_dz;

   always @(posedge CLK) begin
      cyc++;
      m_done = 0;
      if (RST) begin
         m_active = 0;
         m_q      = '0;
         m_r      = '0;
      end else if (m_active) begin
         if (cyc <= m_wr) begin
            if (CANCEL) m_active = 0;
            else if (cyc == m_wr) begin
               m_q    = p_q;
               m_r    = p_r;
               m_done = 1;
            end
         end else begin
            m_active = 0;
         end
      end else if (START && !CANCEL) begin
         ref_div(SIGNED, DIVIDEND, DIVISOR, p_q, p_r, p_dz);
         m_wr     = cyc + (p_dz ? 1 : 33);
         m_active = 1;
      end
      #1;
      if (chk_en) begin
         chk("model busy", 32'(BUSY), 32'(m_active));
         chk("model done", 32'(DONE), 32'(m_done));
         chk("model quotient", QUOTIENT, m_q);
         chk("model remainder", REMAINDER, m_r);
      end
   end

   // Issue one request and follow it to DONE; entered mid-cycle, leaves in the idle cycle after DONE
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                         input string nm);
      int lat;
      int bcnt;
      SIGNED   = s;
      DIVIDEND = a;
      DIVISOR  = b;
      START    = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      lat   = 1;
      bcnt  = BUSY ? 1 : 0;
      while (!DONE && lat < 60) begin
         @(posedge CLK); #1;
         lat++;
         if (BUSY) bcnt++;
      end
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " busy cycles"}, 32'(bcnt), 32'(exp_lat));
      chk({nm, " Q"}, QUOTIENT, eq);
      chk({nm, " R"}, REMAINDER, er);
      @(posedge CLK); #1;
      chk({nm, " busy after"}, 32'(BUSY), 32'd0);
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (BUSY && k < 80) begin
         @(posedge CLK); #1;
         k++;
      end
      chk({nm, " idle timeout"}, 32'(BUSY), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST      = 1'b1;
      START    = 1'b0;
      SIGNED   = 1'b0;
      DIVIDEND = '0;
      DIVISOR  = '0;
      CANCEL   = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST    = 1'b0;
      chk_en = 1;
      chk("reset busy", 32'(BUSY), 32'd0);
      chk("reset done", 32'(DONE), 32'd0);
      chk("reset Q", QUOTIENT, 32'd0);
      chk("reset R", REMAINDER, 32'd0);
      @(posedge CLK); #1;

      run_op(1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, "u100/7");
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s-7/2");
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1, "s7/-2");
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, "s_ovf");
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 34, 32'hFFFF_FFFF, 32'd0, "uMax/1");
      run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 34, 32'd1, 32'h7FFF_FFFF, "uMax/msb");
      run_op(1'b1, 32'd5, 32'd0, 2, 32'hFFFF_FFFF, 32'd5, "div0");
      run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "div0neg");

      // Cancel in cycle 10 of 100/7 after a 9/4 result
      run_op(1'b0, 32'd9, 32'd4, 34, 32'd2, 32'd1, "u9/4");
      SIGNED = 1'b0; DIVIDEND = 32'd100; DIVISOR = 32'd7; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (8) @(posedge CLK);
      #1;
      CANCEL = 1'b1;
      @(posedge CLK); #1;
      CANCEL = 1'b0;
      chk("cancel busy", 32'(BUSY), 32'd0);
      chk("cancel Q hold", QUOTIENT, 32'd2);
      chk("cancel R hold", REMAINDER, 32'd1);
      run_op(1'b0, 32'd9, 32'd3, 34, 32'd3, 32'd0, "u9/3");

      // Reset in the middle of CALC
      SIGNED = 1'b0; DIVIDEND = 32'd100; DIVISOR = 32'd7; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("midrst busy", 32'(BUSY), 32'd0);
      chk("midrst Q", QUOTIENT, 32'd0);
      chk("midrst R", REMAINDER, 32'd0);

      // START held with changing operands while busy must not disturb the result
      SIGNED = 1'b0; DIVIDEND = 32'd1000; DIVISOR = 32'd10; START = 1'b1;
      @(posedge CLK); #1;
      for (int i = 0; i < 20; i++) begin
         DIVIDEND = $urandom;
         DIVISOR  = $urandom;
         SIGNED   = 1'($urandom_range(0, 1));
         @(posedge CLK); #1;
      end
      START = 1'b0;
      begin
         int k;
         k = 0;
         while (!DONE && k < 40) begin
            @(posedge CLK); #1;
            k++;
         end
      end
      chk("held Q", QUOTIENT, 32'd100);
      chk("held R", REMAINDER, 32'd0);
      @(posedge CLK); #1;

      // Randomized divisions with occasional divide by zero and cancels
      for (int n = 0; n < 150; n++) begin
         int mode;
         mode     = int'($urandom_range(0, 7));
         SIGNED   = 1'($urandom_range(0, 1));
         DIVIDEND = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
         case (mode)
            0:       DIVISOR = 32'd0;
            1:       DIVISOR = 32'($urandom_range(1, 15));
            2:       DIVISOR = 32'hFFFF_FFFF;
            3:       DIVISOR = 32'h8000_0000;
            4:       DIVISOR = $urandom >> $urandom_range(0, 31);
            default: DIVISOR = $urandom;
         endcase
         START = 1'b1;
         @(posedge CLK); #1;
         START = 1'b0;
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(0, 35)) @(posedge CLK);
            #1;
            CANCEL = 1'b1;
            @(posedge CLK); #1;
            CANCEL = 1'b0;
         end
         wait_idle("random");
         repeat ($urandom_range(0, 2)) @(posedge CLK);
         #1;
      end

      repeat (3) @(posedge CLK);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
